// File: rtl/mem_update_arbiter.sv
// Board-state update arbiter: buffers local (GameControl) and remote (interboard) updates
// in separate FIFOs and issues them one at a time to MemoryHandle with a commit gap.
module mem_update_arbiter #(
   parameter int LFIFO_DEPTH    = 4,
   parameter int RFIFO_DEPTH    = 2,
   parameter int GAP_CYC        = 2,
   parameter int MAX_REMOTE_RUN = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          interboard_rst,
   input  logic                          ctrl_en,
   input  logic [21:0]                   ctrl_msg,
   input  logic                          interboard_en,
   input  logic [21:0]                   interboard_msg,
   input  logic                          inter_ready,
   output logic                          upd_en,
   output logic                          upd_src,
   output logic [21:0]                   upd_msg,
   output logic                          transmit,
   output logic                          local_full,
   output logic [$clog2(LFIFO_DEPTH):0]  local_cnt,
   output logic                          ovf_err
);

   localparam int LPW = $clog2(LFIFO_DEPTH);
   localparam int RPW = $clog2(RFIFO_DEPTH);
   localparam int LCW = LPW + 1;
   localparam int RCW = RPW + 1;
   localparam int GW  = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
   localparam int RW  = (MAX_REMOTE_RUN > 0) ? $clog2(MAX_REMOTE_RUN + 1) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   logic [21:0]    lmem_q [LFIFO_DEPTH];
   logic [21:0]    rmem_q [RFIFO_DEPTH];
   logic [LPW-1:0] lwr_q, lrd_q;
   logic [RPW-1:0] rwr_q, rrd_q;
   logic [LCW-1:0] lcnt_q, lcnt_d;
   logic [RCW-1:0] rcnt_q, rcnt_d;
   logic           lfull_q, ovf_q;

   state_t         state_q;
   logic [GW-1:0]  gap_q;
   logic [RW-1:0]  run_q;
   logic           upd_en_q, upd_src_q, transmit_q;
   logic [21:0]    upd_msg_q;

   logic elig_r_s, elig_l_s, grant_l_s, grant_r_s, lpush_s, rpush_s;

   // Local wins a contended decision only once remote has had its full run.
   assign elig_r_s  = (rcnt_q != RCW'(0));
   assign elig_l_s  = (lcnt_q != LCW'(0)) && inter_ready;
   assign grant_l_s = (state_q == IDLE) && elig_l_s &&
                      (!elig_r_s || (run_q == RW'(MAX_REMOTE_RUN)));
   assign grant_r_s = (state_q == IDLE) && elig_r_s && !grant_l_s;
   assign lpush_s   = ctrl_en && ((lcnt_q < LCW'(LFIFO_DEPTH)) || grant_l_s);
   assign rpush_s   = interboard_en && ((rcnt_q < RCW'(RFIFO_DEPTH)) || grant_r_s);

   // Next-state occupancy of both FIFOs.
   always_comb begin
      lcnt_d = lcnt_q;
      rcnt_d = rcnt_q;
      if (lpush_s && !grant_l_s) begin
         lcnt_d = lcnt_q + LCW'(1);
      end else if (!lpush_s && grant_l_s) begin
         lcnt_d = lcnt_q - LCW'(1);
      end else begin
         lcnt_d = lcnt_q;
      end
      if (rpush_s && !grant_r_s) begin
         rcnt_d = rcnt_q + RCW'(1);
      end else if (!rpush_s && grant_r_s) begin
         rcnt_d = rcnt_q - RCW'(1);
      end else begin
         rcnt_d = rcnt_q;
      end
   end

   // FIFO storage; contents are meaningless outside the pointer window so no reset.
   always_ff @(posedge clk) begin
      if (lpush_s) lmem_q[lwr_q] <= ctrl_msg;
      if (rpush_s) rmem_q[rwr_q] <= interboard_msg;
   end

   // FIFO pointers, occupancy, full flag and sticky overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lwr_q   <= '0;
         lrd_q   <= '0;
         rwr_q   <= '0;
         rrd_q   <= '0;
         lcnt_q  <= '0;
         rcnt_q  <= '0;
         lfull_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (interboard_rst) begin
         lwr_q   <= '0;
         lrd_q   <= '0;
         rwr_q   <= '0;
         rrd_q   <= '0;
         lcnt_q  <= '0;
         rcnt_q  <= '0;
         lfull_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         lcnt_q  <= lcnt_d;
         rcnt_q  <= rcnt_d;
         lfull_q <= (lcnt_d == LCW'(LFIFO_DEPTH));
         if (lpush_s)   lwr_q <= lwr_q + LPW'(1);
         if (grant_l_s) lrd_q <= lrd_q + LPW'(1);
         if (rpush_s)   rwr_q <= rwr_q + RPW'(1);
         if (grant_r_s) rrd_q <= rrd_q + RPW'(1);
         if ((ctrl_en && !lpush_s) || (interboard_en && !rpush_s)) ovf_q <= 1'b1;
      end
   end

   // Grant FSM with registered strobe outputs and remote-run tracking.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         gap_q      <= '0;
         run_q      <= '0;
         upd_en_q   <= 1'b0;
         upd_src_q  <= 1'b0;
         upd_msg_q  <= '0;
         transmit_q <= 1'b0;
      end else if (interboard_rst) begin
         state_q    <= IDLE;
         gap_q      <= '0;
         run_q      <= '0;
         upd_en_q   <= 1'b0;
         upd_src_q  <= 1'b0;
         upd_msg_q  <= '0;
         transmit_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_l_s) begin
                  state_q    <= GRANT;
                  upd_en_q   <= 1'b1;
                  transmit_q <= 1'b1;
                  upd_src_q  <= 1'b0;
                  upd_msg_q  <= lmem_q[lrd_q];
                  run_q      <= '0;
               end else if (grant_r_s) begin
                  state_q    <= GRANT;
                  upd_en_q   <= 1'b1;
                  transmit_q <= 1'b0;
                  upd_src_q  <= 1'b1;
                  upd_msg_q  <= rmem_q[rrd_q];
                  if (elig_l_s && (run_q != RW'(MAX_REMOTE_RUN))) run_q <= run_q + RW'(1);
               end else begin
                  upd_en_q   <= 1'b0;
                  transmit_q <= 1'b0;
               end
            end
            GRANT: begin
               upd_en_q   <= 1'b0;
               transmit_q <= 1'b0;
               if (GAP_CYC > 0) begin
                  state_q <= GAP;
                  gap_q   <= GW'(GAP_CYC);
               end else begin
                  state_q <= IDLE;
               end
            end
            GAP: begin
               if (gap_q <= GW'(1)) state_q <= IDLE;
               gap_q <= gap_q - GW'(1);
            end
            default: begin
               state_q    <= IDLE;
               upd_en_q   <= 1'b0;
               transmit_q <= 1'b0;
            end
         endcase
      end
   end

   assign upd_en     = upd_en_q;
   assign upd_src    = upd_src_q;
   assign upd_msg    = upd_msg_q;
   assign transmit   = transmit_q;
   assign local_full = lfull_q;
   assign local_cnt  = lcnt_q;
   assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_mem_update_arbiter.sv
// Directed bench for mem_update_arbiter; every grant is checked against a scoreboard of
// expected {src, msg} entries queued in the order the arbitration rules dictate.
module tb_mem_update_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        interboard_rst = 1'b0;
   logic        ctrl_en = 1'b0;
   logic [21:0] ctrl_msg = 22'h0;
   logic        interboard_en = 1'b0;
   logic [21:0] interboard_msg = 22'h0;
   logic        inter_ready = 1'b0;
   logic        upd_en, upd_src, transmit, local_full, ovf_err;
   logic [21:0] upd_msg;
   logic [2:0]  local_cnt;

   int          vectors = 0;
   int          errors  = 0;
   int          cyc     = 0;
   int          last_g  = -1;
   logic [22:0] sb [$];
   bit          src_hist [$];
   int          cyc_hist [$];
   bit          exp_src [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

   mem_update_arbiter dut (
      .clk(clk), .rst(rst), .interboard_rst(interboard_rst),
      .ctrl_en(ctrl_en), .ctrl_msg(ctrl_msg),
      .interboard_en(interboard_en), .interboard_msg(interboard_msg),
      .inter_ready(inter_ready),
      .upd_en(upd_en), .upd_src(upd_src), .upd_msg(upd_msg), .transmit(transmit),
      .local_full(local_full), .local_cnt(local_cnt), .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock; outputs sampled 1 time unit after the edge; grants popped from scoreboard.
   task automatic tick();
      logic [22:0] e;
      @(posedge clk);
      #1;
      cyc++;
      if (upd_en === 1'b1) begin
         chk("sb_nonempty", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("upd_src", upd_src, e[22]);
            chk("upd_msg", upd_msg, e[21:0]);
            chk("transmit_grant", transmit, !e[22]);
         end
         if (last_g >= 0) chk("min_spacing", (cyc - last_g) >= 4, 1);
         last_g = cyc;
         src_hist.push_back(upd_src);
         cyc_hist.push_back(cyc);
      end else begin
         chk("transmit_idle", transmit, 0);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_upd_en"}, upd_en, 0);
      chk({tag, "_upd_src"}, upd_src, 0);
      chk({tag, "_upd_msg"}, upd_msg, 0);
      chk({tag, "_transmit"}, transmit, 0);
      chk({tag, "_local_full"}, local_full, 0);
      chk({tag, "_local_cnt"}, local_cnt, 0);
      chk({tag, "_ovf_err"}, ovf_err, 0);
   endtask

   task automatic push_local(input logic [21:0] m, input bit expect_grant);
      ctrl_en  = 1'b1;
      ctrl_msg = m;
      if (expect_grant) sb.push_back({1'b0, m});
   endtask

   initial begin
      // Power-on reset
      #1 rst = 1'b0;
      #2 check_zero("reset");
      @(posedge clk); #1; rst = 1'b1;
      tick(); tick();

      // Single local message and minimum spacing to the next one
      inter_ready = 1'b1;
      push_local(22'h12345, 1'b1);
      tick(); ctrl_en = 1'b0;
      chk("single_cnt", local_cnt, 1);
      tick();
      chk("single_grant", upd_en, 1);
      push_local(22'h0BEEF, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         tick(); ctrl_en = 1'b0;
         chk("single_spacing", upd_en, (i == 4));
      end
      repeat (4) tick();

      // Link not ready holds local; remote queued as link rises goes after, untransmitted
      inter_ready = 1'b0;
      push_local(22'h2AAAA, 1'b1);
      tick(); ctrl_en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("nolink_no_upd", upd_en, 0);
      end
      inter_ready = 1'b1;
      interboard_en = 1'b1; interboard_msg = 22'h3C3C3;
      sb.push_back({1'b1, 22'h3C3C3});
      tick(); interboard_en = 1'b0;
      chk("link_upd_en", upd_en, 1);
      chk("link_transmit", transmit, 1);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("remote_after_link", upd_en, (i == 4));
      end
      chk("remote_no_tx", transmit, 0);
      repeat (4) tick();

      // Fairness: two remote grants per local under contention
      src_hist.delete(); cyc_hist.delete();
      sb.push_back({1'b1, 22'h10001}); sb.push_back({1'b1, 22'h10002});
      sb.push_back({1'b0, 22'h00A01}); sb.push_back({1'b1, 22'h10003});
      sb.push_back({1'b1, 22'h10004}); sb.push_back({1'b0, 22'h00A02});
      ctrl_en = 1'b1; ctrl_msg = 22'h00A01; interboard_en = 1'b1; interboard_msg = 22'h10001;
      tick();
      ctrl_msg = 22'h00A02; interboard_msg = 22'h10002;
      tick();
      ctrl_en = 1'b0; interboard_msg = 22'h10003;
      tick(); interboard_en = 1'b0;
      tick(); tick(); tick();
      interboard_en = 1'b1; interboard_msg = 22'h10004;
      tick(); interboard_en = 1'b0;
      repeat (16) tick();
      chk("fair_count", src_hist.size(), 6);
      for (int k = 0; k < 6; k++) begin
         if (k < src_hist.size()) chk("fair_src", src_hist[k], exp_src[k]);
         if (k > 0 && k < cyc_hist.size()) chk("fair_gap", cyc_hist[k] - cyc_hist[k-1], 4);
      end
      repeat (4) tick();

      // Push on a full local FIFO in the same cycle as its pop
      inter_ready = 1'b0;
      chk("pushpop_ovf_pre", ovf_err, 0);
      for (int k = 0; k < 4; k++) begin
         push_local(22'h20000 + 22'(k), 1'b1);
         tick();
      end
      ctrl_en = 1'b0;
      chk("full_cnt", local_cnt, 4);
      chk("full_flag", local_full, 1);
      inter_ready = 1'b1;
      push_local(22'h20004, 1'b1);
      tick(); ctrl_en = 1'b0;
      chk("pushpop_upd", upd_en, 1);
      chk("pushpop_cnt", local_cnt, 4);
      chk("pushpop_full", local_full, 1);
      chk("pushpop_ovf", ovf_err, 0);
      repeat (20) tick();
      chk("pushpop_drained", sb.size(), 0);
      chk("pushpop_cnt_end", local_cnt, 0);

      // Overflow: fifth back-to-back push dropped, sticky flag, first four drain in order
      inter_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         push_local(22'h30000 + 22'(k), (k < 4));
         tick();
         chk("ovf_cnt", local_cnt, (k < 4) ? k + 1 : 4);
         chk("ovf_full", local_full, (k >= 3));
         chk("ovf_flag", ovf_err, (k == 4));
      end
      ctrl_en = 1'b0;
      inter_ready = 1'b1;
      repeat (20) tick();
      chk("ovf_drained", sb.size(), 0);
      chk("ovf_sticky", ovf_err, 1);

      // Asynchronous reset in the middle of a commit gap
      inter_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         push_local(22'h3F001 + 22'(k), 1'b1);
         tick();
      end
      ctrl_en = 1'b0;
      chk("rst_fill_cnt", local_cnt, 3);
      inter_ready = 1'b1;
      tick();
      chk("rst_pre_grant", upd_en, 1);
      tick();
      rst = 1'b0;
      #1 check_zero("async_rst");
      sb.delete(); last_g = -1;
      @(posedge clk); #1; rst = 1'b1;
      tick();
      chk("rst_after_cnt", local_cnt, 0);

      // Synchronous flush mid-gap; pushes in the flush cycle are dropped silently
      inter_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         push_local(22'h05A00 + 22'(k), 1'b1);
         tick();
      end
      ctrl_en = 1'b0;
      inter_ready = 1'b1;
      tick();
      chk("flush_pre_grant", upd_en, 1);
      tick();
      sb.delete(); last_g = -1;
      interboard_rst = 1'b1;
      ctrl_en = 1'b1; ctrl_msg = 22'h15555;
      interboard_en = 1'b1; interboard_msg = 22'h2AAAA;
      tick();
      interboard_rst = 1'b0; ctrl_en = 1'b0; interboard_en = 1'b0;
      check_zero("flush");
      repeat (6) tick();
      chk("flush_cnt_end", local_cnt, 0);
      chk("flush_ovf_end", ovf_err, 0);
      chk("flush_no_grants", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
